// File: rtl/l2_fill_ctrl_pkg.sv
// Shared definitions for the L2 instruction-line refill engine:
// fill state encodings, line geometry and access-type codes.
package l2_fill_ctrl_pkg;

  localparam int L2_LINE_W = 512;
  localparam int L2_BEAT_W = 128;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_REQ   = 3'd1,
    F_RECV  = 3'd2,
    F_WRITE = 3'd3,
    F_DONE  = 3'd4,
    F_HOLD  = 3'd5
  } fill_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/l2_line_assembler.sv
// Beat counter plus line register: each valid beat lands in the next
// BEAT_W-wide slot, beat 0 in the least significant bits.
module l2_line_assembler
  import l2_fill_ctrl_pkg::*;
#(
  parameter int BEATS  = L2_LINE_W / L2_BEAT_W,
  parameter int BEAT_W = L2_BEAT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    beat_valid,
  input  logic [BEAT_W-1:0]       beat_data,
  output logic                    last_beat,
  output logic [BEATS*BEAT_W-1:0] line
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [BW-1:0]           beat_r;
  logic [BEATS*BEAT_W-1:0] line_r;

  // Beat slot pointer and line storage; clear restarts the slot pointer only
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_r <= '0;
      line_r <= '0;
    end else if (clear) begin
      beat_r <= '0;
    end else if (beat_valid) begin
      line_r[beat_r*BEAT_W +: BEAT_W] <= beat_data;
      beat_r                          <= beat_r + BW'(1);
    end
  end

  assign last_beat = (beat_r == BW'(BEATS - 1));
  assign line      = line_r;

endmodule

// File: rtl/l2_fill_ctrl.sv
// L2 instruction-line refill engine: requests a line from memory, assembles
// the beats, writes the line into the L2 way and signals completion.
module l2_fill_ctrl
  import l2_fill_ctrl_pkg::*;
#(
  parameter int BEATS   = L2_LINE_W / L2_BEAT_W,
  parameter int BEAT_W  = L2_BEAT_W,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic                    mem_rw,
  input  logic [25:0]             mem_addr,
  output logic                    bus_req,
  output logic [31:0]             bus_addr,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [BEAT_W-1:0]       bus_rd_data,
  output logic [BEATS*BEAT_W-1:0] line_wd,
  output logic                    line_we,
  output logic                    L2_complete,
  output logic                    fill_busy,
  output logic [7:0]              retry_cnt
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  fill_state_e      state_r;
  logic [25:0]      line_addr_r;
  logic [CNT_W-1:0] tmo_r;
  logic             beat_valid_s;
  logic             clear_s;
  logic             last_beat_s;

  assign beat_valid_s = (state_r == F_RECV) && bus_rvalid;

  // Restart the beat slot pointer on every grant and on every timeout refetch
  always_comb begin
    clear_s = 1'b0;
    case (state_r)
      F_REQ: begin
        if (bus_gnt) begin
          clear_s = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      F_RECV: begin
        if (!bus_rvalid && (tmo_r == TMO_LAST)) begin
          clear_s = 1'b1;
        end else begin
          clear_s = 1'b0;
        end
      end
      default: clear_s = 1'b0;
    endcase
  end

  l2_line_assembler #(
    .BEATS  (BEATS),
    .BEAT_W (BEAT_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_s),
    .beat_valid (beat_valid_s),
    .beat_data  (bus_rd_data),
    .last_beat  (last_beat_s),
    .line       (line_wd)
  );

  // Fill sequencing with registered outputs, beat timeout and retry tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= F_IDLE;
      line_addr_r <= 26'd0;
      tmo_r       <= '0;
      bus_req     <= 1'b0;
      bus_addr    <= 32'd0;
      line_we     <= 1'b0;
      L2_complete <= 1'b0;
      fill_busy   <= 1'b0;
      retry_cnt   <= 8'd0;
    end else begin
      case (state_r)
        F_IDLE: begin
          if (miss_req && (mem_rw == RW_READ)) begin
            line_addr_r <= mem_addr;
            bus_addr    <= {mem_addr, 6'b000000};
            bus_req     <= 1'b1;
            fill_busy   <= 1'b1;
            state_r     <= F_REQ;
          end
        end
        F_REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            tmo_r   <= '0;
            state_r <= F_RECV;
          end
        end
        F_RECV: begin
          // A beat on the terminal-count cycle wins over the timeout
          if (bus_rvalid) begin
            tmo_r <= '0;
            if (last_beat_s) begin
              line_we <= 1'b1;
              state_r <= F_WRITE;
            end
          end else if (tmo_r == TMO_LAST) begin
            tmo_r     <= '0;
            retry_cnt <= sat_inc8(retry_cnt);
            bus_req   <= 1'b1;
            bus_addr  <= {line_addr_r, 6'b000000};
            state_r   <= F_REQ;
          end else begin
            tmo_r <= tmo_r + CNT_W'(1);
          end
        end
        F_WRITE: begin
          line_we     <= 1'b0;
          L2_complete <= 1'b1;
          state_r     <= F_DONE;
        end
        F_DONE: begin
          L2_complete <= 1'b0;
          state_r     <= F_HOLD;
        end
        F_HOLD: begin
          if (!miss_req) begin
            fill_busy <= 1'b0;
            state_r   <= F_IDLE;
          end
        end
        default: begin
          state_r     <= F_IDLE;
          bus_req     <= 1'b0;
          line_we     <= 1'b0;
          L2_complete <= 1'b0;
          fill_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_fill_ctrl.sv
// Randomized self-checking bench for l2_fill_ctrl against a transaction-level
// model of the refill: expected line, request count, retries and pulse order.
module tb_l2_fill_ctrl;
  import l2_fill_ctrl_pkg::*;

  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic         mem_rw;
  logic [25:0]  mem_addr;
  logic         bus_req;
  logic [31:0]  bus_addr;
  logic         bus_gnt;
  logic         bus_rvalid;
  logic [127:0] bus_rd_data;
  logic [511:0] line_wd;
  logic         line_we;
  logic         L2_complete;
  logic         fill_busy;
  logic [7:0]   retry_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_retry = 0;

  l2_fill_ctrl #(
    .BEATS(4), .BEAT_W(128), .TIMEOUT(TIMEOUT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .bus_req(bus_req), .bus_addr(bus_addr),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rd_data(bus_rd_data),
    .line_wd(line_wd), .line_we(line_we), .L2_complete(L2_complete),
    .fill_busy(fill_busy), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  // Event monitor: request rises, line writes and completion pulses
  int           cyc = 0;
  int           req_rises = 0;
  int           we_cnt = 0;
  int           done_cnt = 0;
  int           overlap_cnt = 0;
  int           we_cycle = 0;
  int           done_cycle = 0;
  logic         prev_req = 1'b0;
  logic [31:0]  last_req_addr = 32'd0;
  logic [511:0] cap_line = '0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_req <= bus_req;
    if (bus_req && !prev_req) begin
      req_rises     <= req_rises + 1;
      last_req_addr <= bus_addr;
    end
    if (line_we) begin
      we_cnt   <= we_cnt + 1;
      we_cycle <= cyc;
      cap_line <= line_wd;
    end
    if (L2_complete) begin
      done_cnt   <= done_cnt + 1;
      done_cycle <= cyc;
    end
    if (line_we && L2_complete) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int pick_gap(input int mode);
    int g;
    case (mode)
      0: g = 0;
      1: g = $urandom_range(0, 12);
      2: g = 5;
      default: g = TIMEOUT - 1;
    endcase
    return g;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory side: optional stray beats while requesting, grant, then beats
  task automatic grant_and_beats(input int gdelay, input int gap_mode,
                                 input int nbeats, input logic [511:0] data);
    for (int i = 0; i < gdelay; i++) begin
      bus_rvalid  = 1'($urandom_range(0, 1));
      bus_rd_data = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    bus_rvalid = 1'b0;
    bus_gnt    = 1'b1;
    step();
    bus_gnt = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      repeat (pick_gap(gap_mode)) step();
      bus_rvalid  = 1'b1;
      bus_rd_data = data[b*128 +: 128];
      step();
      bus_rvalid = 1'b0;
    end
  endtask

  task automatic run_fill(input logic [25:0] addr, input int gdelay, input int gap_mode,
                          input bit tmo, input logic [511:0] line0,
                          input logic [511:0] line1, input int hold);
    int base_req, base_we, base_done, n;
    logic [511:0] exp_line;
    step();
    base_req  = req_rises;
    base_we   = we_cnt;
    base_done = done_cnt;
    miss_req  = 1'b1;
    mem_rw    = RW_READ;
    mem_addr  = addr;
    n = 0;
    while (!bus_req && n < 20) begin step(); n++; end
    chk("req_seen", bus_req, 1'b1);
    chk("req_addr", bus_addr, {addr, 6'b000000});
    chk("busy_req", fill_busy, 1'b1);
    mem_addr = 26'($urandom);
    grant_and_beats(gdelay, gap_mode, tmo ? 2 : 4, line0);
    exp_line = line0;
    if (tmo) begin
      n = 0;
      while (!bus_req && n < TIMEOUT + 10) begin step(); n++; end
      chk("retry_req", bus_req, 1'b1);
      chk("retry_addr", bus_addr, {addr, 6'b000000});
      exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
      grant_and_beats(0, 0, 4, line1);
      exp_line = line1;
    end
    n = 0;
    while (done_cnt == base_done && n < 300) begin step(); n++; end
    chk("done_once", done_cnt - base_done, 1);
    chk("we_once", we_cnt - base_we, 1);
    chk("done_after_we", done_cycle - we_cycle, 1);
    chk("line", cap_line, exp_line);
    chk("retry_cnt", retry_cnt, exp_retry[7:0]);
    chk("no_overlap", overlap_cnt, 0);
    repeat (hold) step();
    if (hold > 0) chk("hold_busy", fill_busy, 1'b1);
    chk("req_count", req_rises - base_req, tmo ? 2 : 1);
    miss_req = 1'b0;
    step();
    chk("idle_after_drop", fill_busy, 1'b0);
  endtask

  initial begin
    int base_req, base_we, base_done;
    bit bad;
    logic [511:0] l0;
    rst = 1'b1; miss_req = 1'b0; mem_rw = RW_READ; mem_addr = 26'd0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rd_data = 128'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_line_we", line_we, 1'b0);
    chk("rst_complete", L2_complete, 1'b0);
    chk("rst_busy", fill_busy, 1'b0);
    chk("rst_retry", retry_cnt, 8'd0);
    chk("rst_line", line_wd, 512'd0);
    rst = 1'b0;

    // Basic fill
    l0 = {{16{8'hD3}}, {16{8'hC2}}, {16{8'hB1}}, {16{8'hA0}}};
    run_fill(26'h0000123, 2, 0, 1'b0, l0, '0, 0);
    chk("t1_addr", last_req_addr, 32'h000048C0);

    // Gapped beats, then beats landing exactly on the timeout terminal count
    run_fill(26'($urandom), 1, 2, 1'b0, rnd_line(), '0, 0);
    run_fill(26'($urandom), 0, 3, 1'b0, rnd_line(), '0, 0);

    // Timeout with full refetch
    run_fill(26'h2ABCDEF, 1, 1, 1'b1, rnd_line(), rnd_line(), 0);

    // Write access is ignored
    step();
    base_req = req_rises;
    miss_req = 1'b1; mem_rw = RW_WRITE; mem_addr = 26'($urandom);
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus_req || fill_busy) bad = 1'b1;
    end
    step();
    chk("write_ignored", bad, 1'b0);
    chk("write_no_req", req_rises - base_req, 0);
    miss_req = 1'b0; mem_rw = RW_READ;

    // Stale miss level held after completion
    run_fill(26'($urandom), 0, 0, 1'b0, rnd_line(), '0, 10);

    // Reset mid-fill
    step();
    miss_req = 1'b1; mem_rw = RW_READ; mem_addr = 26'h0155555;
    repeat (3) step();
    grant_and_beats(0, 0, 2, rnd_line());
    base_we = we_cnt; base_done = done_cnt;
    rst = 1'b1; miss_req = 1'b0; bus_rvalid = 1'b1; bus_rd_data = {4{$urandom}};
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_bus_req", bus_req, 1'b0);
    chk("mid_rst_bus_addr", bus_addr, 32'd0);
    chk("mid_rst_busy", fill_busy, 1'b0);
    chk("mid_rst_line", line_wd, 512'd0);
    chk("mid_rst_retry", retry_cnt, 8'd0);
    chk("mid_rst_strobes", {line_we, L2_complete}, 2'b00);
    exp_retry = 0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_rvalid  = 1'(i % 2);
      bus_rd_data = {4{$urandom}};
      step();
    end
    bus_rvalid = 1'b0;
    step();
    chk("post_rst_no_we", we_cnt - base_we, 0);
    chk("post_rst_no_done", done_cnt - base_done, 0);
    chk("post_rst_idle", {bus_req, fill_busy}, 2'b00);
    run_fill(26'($urandom), 1, 1, 1'b0, rnd_line(), '0, 0);

    // Randomized fills
    for (int k = 0; k < 6; k++) begin
      run_fill(26'($urandom), $urandom_range(0, 3), $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), rnd_line(), rnd_line(),
               $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
